reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Drives the reset and run window of a downstream counting stage; the downstream stage counts clock edges while out of reset and reports progress. On a `start` pulse the sequencer holds the downstream stage in reset for a fixed number of cycles, releases it for a bounded run window, then re-asserts reset and flags completion. It sits directly upstream of the stage, and its `dut_rst` output connects to that stage's `rst` input.

## Interface
- `HOLD_CYCLES`, default 4: cycles `dut_rst` stays high after `start`. Legal range is ≥1.
- `RUN_CYCLES`, default 10: unpaused cycles in the run window. Legal range is ≥1 and < 2^`CTR_W`.
- `CTR_W`, default 32: width of `cycle_count`.
- `clk`, input, 1: the single clock. All logic is on `posedge clk`.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: request to begin a sequence. Sampled on `posedge clk`.
- `pause`, input, 1: freezes run progress while high.
- `dut_rst`, output, 1: reset for the downstream stage. Active-high.
- `running`, output, 1: high while in the run window.
- `done`, output, 1: high once the run window has completed.
- `cycle_count`, output, `CTR_W`: number of unpaused run cycles so far.

## Operation
- The FSM has four states: IDLE, HOLD, RUN, DONE. All outputs are registered (Moore-style); no output is combinational from an input.
- Reset (`rst`=1 at an edge): state goes to IDLE, `dut_rst`=1, `running`=0, `done`=0, `cycle_count`=0, and the hold counter is cleared.
- IDLE:
  - `dut_rst`=1.
  - `start`=1 moves to HOLD and clears the hold counter.
- HOLD:
  - `dut_rst`=1.
  - The hold counter increments every cycle, independent of `pause`.
  - After HOLD_CYCLES cycles in HOLD, move to RUN.
  - `start` is ignored.
- RUN:
  - `dut_rst`=0, `running`=1.
  - Each cycle with `pause`=0 increments `cycle_count`.
  - The increment that makes `cycle_count` equal RUN_CYCLES also moves the state to DONE.
  - When `pause`=1: `cycle_count` holds and `dut_rst` stays 0.
  - `start` is ignored.
- DONE:
  - `dut_rst`=1, `running`=0, `done`=1.
  - `cycle_count` holds RUN_CYCLES.
  - `start`=1 moves to HOLD, clears `cycle_count` and `done` at that edge, and clears the hold counter.
- Width rules:
  - `cycle_count` never exceeds RUN_CYCLES, so it cannot wrap.
  - The hold counter is `$clog2(HOLD_CYCLES+1)` bits wide.
- Simultaneous events:
  - `rst` wins over `start` and `pause`.
  - `start` together with `pause` in DONE still restarts.
  - In RUN, `pause`=1 on the final cycle delays the DONE transition.
- Reset mid-operation (in HOLD or RUN): the block returns to IDLE on the next edge. `dut_rst` is re-asserted at that edge and `cycle_count` is cleared.

## Timing
- Take `start` sampled high at edge t while in IDLE.
- State is HOLD from edge t through edge t+HOLD_CYCLES. `dut_rst` is 1 throughout.
- At edge t+HOLD_CYCLES the state becomes RUN:
  - `dut_rst` falls.
  - `running` rises.
  - `cycle_count` = 0.
- With no pause:
  - `cycle_count` = k after edge t+HOLD_CYCLES+k.
  - At edge t+HOLD_CYCLES+RUN_CYCLES: `done` rises, `running` falls, `dut_rst` rises.
- Each paused RUN cycle adds exactly one cycle to the end time.
- Restart from DONE has the same latency as a start from IDLE.

## Structure
- Package `reset_seq_pkg` holds:
  - the `seq_state_t` enum (IDLE, HOLD, RUN, DONE);
  - the default width constant `SEQ_CTR_W` = 32.
- One sub-module is natural: `seq_counter`, a parameterised-width counter with clear, enable and terminal-count compare. It is instantiated twice, once for hold and once for run.
- The top level contains the FSM and the output registers only.

## Test plan
- Reset behaviour: `rst`=1 for 2 cycles, then released with `start`=0 → `dut_rst`=1, `running`=0, `done`=0, `cycle_count`=0, held indefinitely.
- Basic sequence: HOLD_CYCLES=4, RUN_CYCLES=10, `start` pulsed at edge 5 → `dut_rst` low exactly on edges 9..18, `done`=1 from edge 19, `cycle_count`=10.
- Pause: same setup with `pause`=1 for 3 cycles mid-run → `done` at edge 22, `cycle_count` frozen during the pause, `dut_rst` stays 0 during the pause.
- Ignored start: `start` re-pulsed during HOLD and during RUN → no change in timing or count.
- Restart: `start` pulsed in DONE → `done` cleared, `cycle_count`=0, full sequence repeats with identical latency.
- Reset mid-run: `rst`=1 when `cycle_count`=6 → next edge gives IDLE, `dut_rst`=1, `cycle_count`=0, `running`=0.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding and default widths for the reset sequencer
package reset_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, RUN = 2'd2, DONE = 2'd3} seq_state_t;
  localparam int SEQ_CTR_W = 32;
endpackage

// File: rtl/seq_counter.sv
// seq_counter: clearable, enabled up-counter flagging the cycle before it reaches TERM
module seq_counter #(
  parameter int W = 8,
  parameter int TERM = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         last
);
  assign last = q == W'(TERM - 1);
  always_ff @(posedge clk)
    q <= (rst || clr) ? '0 : en ? q + W'(1) : q;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds a downstream stage in reset, opens a bounded run window, then flags done
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int RUN_CYCLES = 10,
  parameter int CTR_W = SEQ_CTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  output logic             dut_rst,
  output logic             running,
  output logic             done,
  output logic [CTR_W-1:0] cycle_count
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  seq_state_t state, nxt;
  logic go, hold_last, run_last;
  logic [HW-1:0] hold_unused;
  seq_counter #(.W(HW), .TERM(HOLD_CYCLES)) u_hold (
    .clk(clk), .rst(rst), .clr(go), .en(state == HOLD), .q(hold_unused), .last(hold_last)
  );
  seq_counter #(.W(CTR_W), .TERM(RUN_CYCLES)) u_run (
    .clk(clk), .rst(rst), .clr(go), .en(state == RUN && !pause), .q(cycle_count), .last(run_last)
  );
  always_comb begin
    go = start && (state == IDLE || state == DONE);
    nxt = go ? HOLD :
          (state == HOLD && hold_last) ? RUN :
          (state == RUN && !pause && run_last) ? DONE : state;
  end
  // outputs are registered from the next state so they change on the same edge as the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dut_rst <= 1'b1;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nxt;
      dut_rst <= nxt != RUN;
      running <= nxt == RUN;
      done    <= nxt == DONE;
    end
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: table vectors, corner-case sequences and random stimulus against a behavioural model
module tb_reset_sequencer;
  localparam int H = 4;
  localparam int R = 10;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, pause = 1'b0;
  logic dut_rst, running, done;
  logic [31:0] cycle_count;
  int total = 0, bad = 0;
  bit m_seq = 0, m_fin = 0;
  int m_hold = 0, m_cnt = 0;
  typedef struct {
    bit r, s, p, e_rst, e_run, e_done;
    int e_cnt;
  } vec_t;
  vec_t tbl[24];

  always #5 clk = ~clk;

  reset_sequencer #(.HOLD_CYCLES(H), .RUN_CYCLES(R), .CTR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .dut_rst(dut_rst), .running(running), .done(done), .cycle_count(cycle_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // sequence seen as "hold cycles left, then count unpaused cycles up to R"
  task automatic model_edge(input bit r, input bit s, input bit p);
    if (r) begin
      m_seq = 0; m_fin = 0; m_cnt = 0; m_hold = 0;
    end else if (!m_seq && s) begin
      m_seq = 1; m_fin = 0; m_cnt = 0; m_hold = H;
    end else if (m_seq) begin
      if (m_hold > 0) m_hold--;
      else if (!p) begin
        m_cnt++;
        if (m_cnt == R) begin
          m_seq = 0; m_fin = 1;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit p);
    bit m_run;
    rst = r; start = s; pause = p;
    @(posedge clk);
    model_edge(r, s, p);
    #1;
    m_run = m_seq && m_hold == 0;
    chk("model_dut_rst", dut_rst, !m_run);
    chk("model_running", running, m_run);
    chk("model_done", done, m_fin);
    chk("model_count", cycle_count, m_cnt);
  endtask

  initial begin
    for (int i = 0; i < 24; i++) begin
      tbl[i].r = i < 2;
      tbl[i].s = i == 5 || i == 7 || i == 12;
      tbl[i].p = 0;
      tbl[i].e_run = i >= 9 && i <= 18;
      tbl[i].e_rst = !tbl[i].e_run;
      tbl[i].e_done = i >= 19;
      tbl[i].e_cnt = i < 9 ? 0 : i <= 18 ? i - 9 : R;
    end
    for (int i = 0; i < 24; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].p);
      chk("vec_dut_rst", dut_rst, tbl[i].e_rst);
      chk("vec_running", running, tbl[i].e_run);
      chk("vec_done", done, tbl[i].e_done);
      chk("vec_count", cycle_count, tbl[i].e_cnt);
    end
    step(1, 0, 0);
    step(0, 1, 0);
    repeat (4) step(0, 0, 0);
    chk("pause_run_start", running, 1);
    repeat (3) step(0, 0, 0);
    chk("pause_pre_count", cycle_count, 3);
    repeat (3) begin
      step(0, 0, 1);
      chk("pause_frozen", cycle_count, 3);
      chk("pause_dut_rst", dut_rst, 0);
    end
    repeat (6) step(0, 0, 0);
    chk("pause_not_done", done, 0);
    chk("pause_count9", cycle_count, 9);
    step(0, 0, 0);
    chk("pause_done", done, 1);
    chk("pause_final", cycle_count, R);
    step(0, 1, 1);
    chk("restart_done_clr", done, 0);
    chk("restart_count_clr", cycle_count, 0);
    chk("restart_dut_rst", dut_rst, 1);
    repeat (3) step(0, 0, 0);
    chk("restart_still_hold", running, 0);
    step(0, 0, 0);
    chk("restart_run", running, 1);
    repeat (6) step(0, 0, 0);
    chk("midrun_count6", cycle_count, 6);
    step(1, 1, 1);
    chk("midrun_rst_dut_rst", dut_rst, 1);
    chk("midrun_rst_count", cycle_count, 0);
    chk("midrun_rst_running", running, 0);
    chk("midrun_rst_done", done, 0);
    repeat (5) begin
      step(0, 0, 0);
      chk("idle_dut_rst", dut_rst, 1);
      chk("idle_running", running, 0);
    end
    for (int i = 0; i < 3000; i++)
      step($urandom % 64 == 0, $urandom % 8 == 0, $urandom % 4 == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
